// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_pkg;

  // Frame sequencing states of the transmit engine.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_e;

  // Bit positions inside uart_mode.
  localparam int MODE_PAR_EN  = 0;
  localparam int MODE_PAR_ODD = 1;
  localparam int MODE_STOP2   = 2;
  localparam int MODE_W       = 3;

  // Smallest clocks-per-bit value the engine will accept.
  localparam int UART_MIN_RATE = 2;

  // Parity bit for a frame: accumulated data parity, flipped for odd mode.
  function automatic logic parity_bit(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Valid/ready byte handshake between a byte source and the transmit engine.
interface uart_tx_engine_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Byte source side.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmit engine side.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: a loadable down-counter that ticks on the last cycle of
// every serial bit and reloads itself so consecutive bits stay back to back.
module uart_baud_tick #(
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [RATE_WIDTH-1:0] load_val,
  input  logic [RATE_WIDTH-1:0] reload_val,
  output logic                  bit_tick
);

  logic [RATE_WIDTH-1:0] cnt_q;
  logic [RATE_WIDTH-1:0] cnt_d;

  // A frame start loads first; the idle clear only applies otherwise, so a
  // handshake taken while idle still arms the counter for the start bit.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = reload_val;
    end else begin
      cnt_d = cnt_q - RATE_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = !clear && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: accepts bytes over a valid/ready handshake, latches
// the frame configuration at acceptance and serialises start, data (LSB
// first), optional parity and one or two stop bits onto tx_o.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int RATE_WIDTH = 16,
  parameter int MIN_RATE   = UART_MIN_RATE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_enable,
  input  logic [MODE_W-1:0]     uart_mode,
  input  logic [RATE_WIDTH-1:0] uart_rate,
  uart_tx_engine_if.slave       tx_if,
  output logic                  tx_o,
  output logic                  uart_busy,
  output logic                  uart_error,
  output logic                  update_ok,
  output logic                  tx_done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_tx_state_e        state_q, state_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  par_q, par_d;
  logic                  stop_q, stop_d;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic                  tx_o_q, tx_o_d;
  logic                  err_q, err_d;

  logic handshake;
  logic rate_bad;
  logic frame_start;
  logic bit_tick;
  logic last_stop;

  assign tx_if.tx_ready = (state_q == ST_IDLE) && uart_enable;
  assign handshake      = tx_if.tx_valid && tx_if.tx_ready;
  assign rate_bad       = (uart_rate < RATE_WIDTH'(MIN_RATE));
  assign frame_start    = handshake && !rate_bad;
  assign last_stop      = (stop_q == mode_q[MODE_STOP2]);

  uart_baud_tick #(
    .RATE_WIDTH (RATE_WIDTH)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state_q == ST_IDLE),
    .load       (frame_start),
    .load_val   (uart_rate - RATE_WIDTH'(1)),
    .reload_val (rate_q - RATE_WIDTH'(1)),
    .bit_tick   (bit_tick)
  );

  // Next-state and next-bit logic; tx_o_d always carries the level of the
  // bit that begins after the coming edge, so tx_o is a clean flop output.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    stop_d  = stop_q;
    mode_d  = mode_q;
    rate_d  = rate_q;
    tx_o_d  = tx_o_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_o_d = 1'b1;
        if (handshake) begin
          if (rate_bad) begin
            // Byte is consumed but never sent.
            err_d = 1'b1;
          end else begin
            state_d = ST_START;
            tx_o_d  = 1'b0;
            shift_d = tx_if.tx_data;
            mode_d  = uart_mode;
            rate_d  = uart_rate;
            idx_d   = '0;
            par_d   = 1'b0;
            stop_d  = 1'b0;
          end
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          tx_o_d  = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          par_d = par_q ^ shift_q[0];
          if (idx_q == LAST_IDX) begin
            if (mode_q[MODE_PAR_EN]) begin
              state_d = ST_PARITY;
              tx_o_d  = parity_bit(par_q ^ shift_q[0], mode_q[MODE_PAR_ODD]);
            end else begin
              state_d = ST_STOP;
              tx_o_d  = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
            tx_o_d  = shift_d[0];
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          tx_o_d  = 1'b1;
        end
      end
      ST_STOP: begin
        tx_o_d = 1'b1;
        if (bit_tick) begin
          if (last_stop) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            stop_d  = 1'b0;
            par_d   = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_o_d  = 1'b1;
      end
    endcase
  end

  // FSM and frame registers; reset drops any frame in flight and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      mode_q  <= '0;
      rate_q  <= '0;
      tx_o_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      mode_q  <= mode_d;
      rate_q  <= rate_d;
      tx_o_q  <= tx_o_d;
      err_q   <= err_d;
    end
  end

  assign tx_o       = tx_o_q;
  assign uart_error = err_q;
  assign uart_busy  = (state_q != ST_IDLE);
  assign update_ok  = (state_q == ST_IDLE);
  assign tx_done    = (state_q == ST_STOP) && bit_tick && last_stop;

endmodule
